booth_product_accumulator: RTL
==============================

# booth_product_accumulator

Downstream consumer of the 4-bit Booth multiplier's 8-bit signed product. Accumulates a frame of 1–16 products into a saturating signed sum and presents the result on a valid/ready output. Input and output both use valid/ready handshakes. Sits between the multiplier array and the dot-product/result logic.

## Interface
- ACC_W, 10: accumulator width, two's complement; legal range 9..16.
- COUNT_W, 4: width of frame_len; maximum frame is 2^COUNT_W products.

- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- prod_in  input  8  signed product from the multiplier (range -56..+64).
- prod_valid  input  1  prod_in is valid.
- prod_ready  output  1  block accepts prod_in this cycle.
- frame_len  input  COUNT_W  products per frame; 0 means 2^COUNT_W; sampled only on a frame's first accept.
- clear  input  1  synchronous abort; discards the partial frame.
- acc_out  output  ACC_W  signed accumulator; meaningful while acc_valid=1.
- acc_valid  output  1  frame result available.
- acc_ready  input  1  consumer takes the result.
- sat  output  1  sticky; some addition in the current frame clipped.
- busy  output  1  frame in progress or result pending (state != IDLE).

## Operation
- Accept: prod_valid && prod_ready at a rising edge.
- prod_ready = 1 in IDLE and ACCUM, 0 in HOLD (decoded from state).
- Sign-extend prod_in to ACC_W before any arithmetic.
- Saturating add: compute in ACC_W+1 bits. Clip to +(2^(ACC_W-1)-1) or -2^(ACC_W-1). On clip, set sat. Later adds continue from the clipped value.
- Internal counter is COUNT_W+1 bits. Latched length L = frame_len, or 2^COUNT_W if frame_len=0.
- IDLE:
  - On accept: acc_out <= sext(prod_in) (load, no add), sat <= 0, count <= 1, latch L.
  - Then go to HOLD if L=1, else ACCUM.
- ACCUM:
  - On accept: acc_out <= sat_add(acc_out, prod_in), count <= count+1.
  - When the new count equals L, go to HOLD.
  - No accept: hold all state.
- HOLD:
  - acc_valid=1. acc_out and sat are stable. No products are accepted.
  - On acc_ready, go to IDLE.
- clear=1 at an edge:
  - State goes to IDLE and count to 0. acc_valid deasserts next cycle.
  - acc_out and sat keep their values until the next frame's first accept.
  - clear takes priority over a simultaneous accept or output handshake; that product is dropped.
- frame_len changes after the first accept have no effect until the next frame.
- Reset values: state=IDLE, acc_out=0, acc_valid=0, sat=0, busy=0, count=0; prod_ready=1 once rst_n is high.
- rst_n low in any state, including mid-frame or HOLD, forces reset values immediately (asynchronously).

## Timing
- Throughput: one product per cycle in IDLE/ACCUM.
- Latency: acc_valid rises on the edge that accepts the L-th product, so it is visible the following cycle.
- The output handshake completes at the edge where acc_valid && acc_ready. From the next cycle, acc_valid=0 and prod_ready=1.
- Minimum frame period: L+1 cycles, due to one HOLD bubble. No accept is possible in the handshake cycle itself.
- No combinational path from prod_in or acc_ready to any output except through state. prod_ready depends on state only.
- Release of rst_n is synchronous to clk at the integration level. The first accept can occur on the first edge after release.

## Test plan
- Reset: pulse rst_n low mid-ACCUM with no clock edge -> acc_out=0, acc_valid=0, sat=0, busy=0 immediately; prod_ready=1 after release.
- frame_len=3, products 20, -56, 64 back-to-back -> acc_out=28 (0x01C), sat=0. acc_valid rises exactly one cycle after the 3rd accept.
- Saturation: frame_len=0 (16 products), 16×64 -> acc_out=511, sat=1. Then 16×(-56) -> acc_out=-512 (0x200), sat=1. A following frame_len=1 frame with 5 -> sat=0.
- Backpressure: hold acc_ready=0 for 5 cycles in HOLD with prod_valid=1 -> acc_out and acc_valid stable, prod_ready=0, no product consumed. Release -> IDLE, next product loads as the first of a new frame.
- Abort: frame_len=4, accept 10, 10, then clear=1 together with prod_valid=1 -> IDLE, that product dropped, acc_valid never asserted. Next frame_len=1 with -7 -> acc_out=0x3F9.
- Mid-frame frame_len change: start with frame_len=2, switch to 5 after the first accept -> result after 2 products.

Source files
------------

// File: rtl/booth_product_accumulator_if.sv
// Valid/ready bundle between the Booth multiplier, the accumulator and the result consumer.
// The master side drives products and takes results; the slave side is the accumulator.
interface booth_product_accumulator_if #(
  parameter int unsigned ACC_W = 10
) ();
  logic signed [7:0]       prod_in;
  logic                    prod_valid;
  logic                    prod_ready;
  logic signed [ACC_W-1:0] acc_out;
  logic                    acc_valid;
  logic                    acc_ready;

  modport master (
    output prod_in, prod_valid, acc_ready,
    input  prod_ready, acc_out, acc_valid
  );

  modport slave (
    input  prod_in, prod_valid, acc_ready,
    output prod_ready, acc_out, acc_valid
  );
endinterface

// File: rtl/booth_product_accumulator.sv
// Accumulates a frame of 1..2^COUNT_W signed 8-bit products into a saturating ACC_W-bit sum
// and holds the result on a valid/ready output until the consumer takes it.
module booth_product_accumulator #(
  parameter int unsigned ACC_W   = 10,
  parameter int unsigned COUNT_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  booth_product_accumulator_if.slave  bus,
  input  logic [COUNT_W-1:0]          frame_len,
  input  logic                        clear,
  output logic                        sat,
  output logic                        busy
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  localparam logic [ACC_W-1:0]   SatMax   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]   SatMin   = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [COUNT_W:0]   CountOne = {{COUNT_W{1'b0}}, 1'b1};
  localparam logic [COUNT_W:0]   LenMax   = {1'b1, {COUNT_W{1'b0}}};

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               sat_q, sat_d;
  logic [COUNT_W:0]   count_q, count_d;
  logic [COUNT_W:0]   len_q, len_d;

  logic               accept;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W:0]     sum;
  logic               ovf;
  logic [ACC_W-1:0]   add_res;
  logic [COUNT_W:0]   len_new;
  logic [COUNT_W:0]   count_inc;

  assign accept   = bus.prod_valid && (state_q != StHold);
  assign prod_ext = {{(ACC_W-8){bus.prod_in[7]}}, bus.prod_in};

  // One guard bit: overflow shows up as disagreement between the top two sum bits.
  assign sum      = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
  assign ovf      = sum[ACC_W] ^ sum[ACC_W-1];
  assign add_res  = ovf ? (sum[ACC_W] ? SatMin : SatMax) : sum[ACC_W-1:0];

  assign len_new   = (frame_len == '0) ? LenMax : {1'b0, frame_len};
  assign count_inc = count_q + CountOne;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    count_d = count_q;
    len_d   = len_q;

    if (clear) begin
      // Abort wins over any handshake; acc/sat linger until the next frame loads.
      state_d = StIdle;
      count_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            acc_d   = prod_ext;
            sat_d   = 1'b0;
            count_d = CountOne;
            len_d   = len_new;
            state_d = (len_new == CountOne) ? StHold : StAccum;
          end
        end
        StAccum: begin
          if (accept) begin
            acc_d   = add_res;
            sat_d   = sat_q | ovf;
            count_d = count_inc;
            if (count_inc == len_q) state_d = StHold;
          end
        end
        StHold: begin
          if (bus.acc_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      count_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

  assign bus.prod_ready = (state_q != StHold);
  assign bus.acc_valid  = (state_q == StHold);
  assign bus.acc_out    = acc_q;
  assign sat            = sat_q;
  assign busy           = (state_q != StIdle);

endmodule
